// File: rtl/serial_adder.sv
// Digit-serial adder: {co,sum} = a + b + ci, DIGIT bits per clock, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that turns the operation into a - b.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_next;
  logic [WIDTH-1:0]   b_load;
  logic               carry, carry_load;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT-1:0]   slice_sum;
  logic               slice_co;
  logic               last_digit;

  // Subtraction is a + ~b + 1, so only the loaded B and initial carry differ.
  always_comb begin
    b_load     = b;
    carry_load = ci;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  always_comb begin
    {slice_co, slice_sum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                          + {{DIGIT{1'b0}}, carry};
    // New digit enters at the MSB end; written as a shift so N=1 needs no empty slice.
    res_next   = WIDTH'({slice_sum, res_sh} >> DIGIT);
    last_digit = (cnt == CNT_W'(N - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: only control and visible outputs are reset; the operand and partial-result
  // shift registers are always reloaded or overwritten before they are observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b_load;
          carry <= carry_load;
          cnt   <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= slice_co;
          cnt    <= cnt + CNT_W'(1);
          if (last_digit) begin
            sum <= res_next;
            co  <= slice_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT = 1, 4, 8 at WIDTH = 8) checked
// against an arithmetic model of a + b + ci (or a - b with SERIAL_ADDER_SUB_EN).
module tb_serial_adder;

  localparam int W  = 8;
  localparam int NU = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_v [NU];
  logic [W-1:0] a_v     [NU];
  logic [W-1:0] b_v     [NU];
  logic         ci_v    [NU];
  logic         sub_v   [NU];
  logic         ready_v [NU];
  logic         busy_v  [NU];
  logic         done_v  [NU];
  logic [W-1:0] sum_v   [NU];
  logic         co_v    [NU];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .ci(ci_v[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[0]),
`endif
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .co(co_v[0])
  );

  serial_adder #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .ci(ci_v[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[1]),
`endif
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .co(co_v[1])
  );

  serial_adder #(.WIDTH(W), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .ci(ci_v[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[2]),
`endif
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .co(co_v[2])
  );

  function automatic int n_of(input int u);
    return (u == 0) ? 8 : (u == 1) ? 2 : 1;
  endfunction

  function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                       input logic tci, input logic tsub);
    logic [W-1:0] diff;
    if (tsub) begin
      diff = ta - tb;
      return {(ta >= tb), diff};
    end
    return {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
  endfunction

  function automatic logic rand_sub();
`ifdef SERIAL_ADDER_SUB_EN
    return 1'($urandom);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on unit u, with latency, hold and no-partial checks.
  task automatic op(input int u, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tci, input logic tsub, input string tag);
    logic [W:0]   exp;
    logic [W-1:0] held_sum;
    logic         held_co;
    int           n;
    n        = n_of(u);
    exp      = model(ta, tb, tci, tsub);
    held_sum = sum_v[u];
    held_co  = co_v[u];
    n_checks++;
    if (ready_v[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_start: got %b want 1", tag, ready_v[u]);
    end
    start_v[u] = 1'b1; a_v[u] = ta; b_v[u] = tb; ci_v[u] = tci; sub_v[u] = tsub;
    tick();
    start_v[u] = 1'b0;
    a_v[u] = W'($urandom); b_v[u] = W'($urandom); ci_v[u] = 1'($urandom); sub_v[u] = rand_sub();
    n_checks++;
    if (busy_v[u] !== 1'b1 || ready_v[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_accept: got busy=%b ready=%b want busy=1 ready=0",
               tag, busy_v[u], ready_v[u]);
    end
    for (int k = 1; k <= n; k++) begin
      tick();
      n_checks++;
      if (k < n) begin
        if (done_v[u] !== 1'b0 || sum_v[u] !== held_sum || co_v[u] !== held_co) begin
          n_fail++;
          $display("FAIL %s partial_k%0d: got done=%b co=%b sum=%h want done=0 co=%b sum=%h",
                   tag, k, done_v[u], co_v[u], sum_v[u], held_co, held_sum);
        end
      end else begin
        if (done_v[u] !== 1'b1 || {co_v[u], sum_v[u]} !== exp) begin
          n_fail++;
          $display("FAIL %s result: got done=%b co=%b sum=%h want done=1 co=%b sum=%h",
                   tag, done_v[u], co_v[u], sum_v[u], exp[W], exp[W-1:0]);
        end
      end
    end
    tick();
    n_checks++;
    if (done_v[u] !== 1'b0 || ready_v[u] !== 1'b1 || {co_v[u], sum_v[u]} !== exp) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b ready=%b co=%b sum=%h want done=0 ready=1 co=%b sum=%h",
               tag, done_v[u], ready_v[u], co_v[u], sum_v[u], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      start_v[u] = 1'b1; a_v[u] = 8'hFF; b_v[u] = 8'hFF; ci_v[u] = 1'b1; sub_v[u] = 1'b0;
    end
    tick();
    tick();
    for (int u = 0; u < NU; u++) begin
      n_checks++;
      if (ready_v[u] !== 1'b1 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 ||
          sum_v[u] !== 8'h00 || co_v[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_u%0d: got ready=%b busy=%b done=%b co=%b sum=%h want 1 0 0 0 00",
                 u, ready_v[u], busy_v[u], done_v[u], co_v[u], sum_v[u]);
      end
      start_v[u] = 1'b0;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    op(0, 8'h00, 8'h00, 1'b0, 1'b0, "zero");
    op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1");
    op(0, 8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a_ci");
    op(1, 8'h3C, 8'hC4, 1'b0, 1'b0, "digit4");
    op(2, 8'hFF, 8'hFF, 1'b1, 1'b0, "digit8_max");
    op(2, 8'h00, 8'h00, 1'b1, 1'b0, "digit8_ci");
`ifdef SERIAL_ADDER_SUB_EN
    op(0, 8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
    op(0, 8'h01, 8'h02, 1'b1, 1'b1, "sub_01_02");
    op(1, 8'h80, 8'h80, 1'b0, 1'b1, "sub_equal");
`endif
  endtask

  task automatic test_random();
    for (int u = 0; u < NU; u++)
      for (int i = 0; i < 12; i++)
        op(u, W'($urandom), W'($urandom), 1'($urandom), rand_sub(), $sformatf("rand_u%0d_%0d", u, i));
  endtask

  task automatic test_start_ignored();
    logic [W:0] exp;
    int         dones;
    int         n;
    n     = n_of(0);
    exp   = model(8'h12, 8'h34, 1'b1, 1'b0);
    dones = 0;
    start_v[0] = 1'b1; a_v[0] = 8'h12; b_v[0] = 8'h34; ci_v[0] = 1'b1; sub_v[0] = 1'b0;
    tick();
    start_v[0] = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      if (k == 3 || k == 5) begin
        start_v[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'hFF; ci_v[0] = 1'b1;
      end else begin
        start_v[0] = 1'b0;
      end
      tick();
      if (done_v[0] === 1'b1) dones++;
      if (k == n) begin
        n_checks++;
        if (done_v[0] !== 1'b1 || {co_v[0], sum_v[0]} !== exp) begin
          n_fail++;
          $display("FAIL start_ignored_result: got done=%b co=%b sum=%h want done=1 co=%b sum=%h",
                   done_v[0], co_v[0], sum_v[0], exp[W], exp[W-1:0]);
        end
      end
    end
    n_checks++;
    if (dones != 1 || busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_pulses: got dones=%0d busy=%b ready=%b want 1 0 1",
               dones, busy_v[0], ready_v[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    start_v[0] = 1'b1; a_v[0] = 8'hC3; b_v[0] = 8'h3C; ci_v[0] = 1'b1; sub_v[0] = 1'b0;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 ||
        sum_v[0] !== 8'h00 || co_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got ready=%b busy=%b done=%b co=%b sum=%h want 1 0 0 0 00",
               ready_v[0], busy_v[0], done_v[0], co_v[0], sum_v[0]);
    end
    for (int k = 0; k < n_of(0) + 2; k++) begin
      tick();
      if (done_v[0] === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_run_no_done: got %0d done pulses want 0", dones);
    end
    op(0, 8'hC3, 8'h3C, 1'b1, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
